// File: rtl/if_id_buffer_pkg.sv
// rtl/if_id_buffer_pkg.sv - shared constants and entry type for the IF/ID buffer
package if_id_buffer_pkg;

  localparam logic [31:0] NOP_INST    = 32'h00000013;
  localparam int          IF_ID_DEPTH = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } if_id_entry_t;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_id_buffer.sv
// rtl/if_id_buffer.sv - two-entry IF/ID skid buffer with registered head outputs
module if_id_buffer
  import if_id_buffer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_inst,
  input  logic        id_ready,
  input  logic        flush,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc4,
  output logic        pc_stall,
  output logic [1:0]  occupancy
);

  if_id_entry_t entries [IF_ID_DEPTH];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;

  logic         push;
  logic         pop;
  logic         rd_next;
  logic [1:0]   count_next;
  if_id_entry_t in_entry;
  if_id_entry_t head_next;

  // pc_stall is the registered full flag, so a pop from full never admits a push
  always_comb begin
    push       = if_valid & ~pc_stall & ~flush;
    pop        = id_valid & id_ready & ~flush;
    rd_next    = rd_ptr ^ pop;
    count_next = count + 2'(push) - 2'(pop);
    in_entry   = '{pc: if_pc, inst: if_inst};
    head_next  = entries[rd_next];
    if (push && (wr_ptr == rd_next)) begin
      head_next = in_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
      pc_stall <= 1'b0;
      id_valid <= 1'b0;
      id_pc    <= 32'd0;
      id_pc4   <= 32'd4;
      id_inst  <= NOP_INST;
    end else if (flush) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
      pc_stall <= 1'b0;
      id_valid <= 1'b0;
      id_inst  <= NOP_INST;
    end else begin
      if (push) begin
        entries[wr_ptr] <= in_entry;
      end
      wr_ptr   <= wr_ptr ^ push;
      rd_ptr   <= rd_next;
      count    <= count_next;
      pc_stall <= (count_next == 2'd2);
      id_valid <= (count_next != 2'd0);
      // Empty head keeps the last pc/pc4 and presents a NOP
      if (count_next != 2'd0) begin
        id_pc   <= head_next.pc;
        id_pc4  <= pc_plus4(head_next.pc);
        id_inst <= head_next.inst;
      end else begin
        id_inst <= NOP_INST;
      end
    end
  end

  assign occupancy = count;

endmodule
